// File: rtl/cpu_ram_pkg.sv
// rtl/cpu_ram_pkg.sv - shared FSM state type and write-mode constants for the scratch RAM
package cpu_ram_pkg;

    // Controller state: normal CPU access, or the zeroing sweep
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_state_t;

    // Q behaviour on a CPU write cycle
    localparam int WM_NORMAL          = 0;  // Q keeps its previous value
    localparam int WM_WRITETHROUGH    = 1;  // Q shows the word just written
    localparam int WM_READBEFOREWRITE = 2;  // Q shows the word being overwritten

endpackage

// File: rtl/cpu_ram_core.sv
// rtl/cpu_ram_core.sv - plain single-port synchronous RAM array, no reset
//
// Ports:
//   i_clk    - clock, rising edge
//   i_we     - write i_wdata to i_addr
//   i_re     - capture the word at i_addr into o_rdata (old contents on a write)
//   i_addr   - word address
//   i_wdata  - write data
//   o_rdata  - registered read data, holds while i_re is low
module cpu_ram_core #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int LP_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [LP_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read-first: a simultaneous read and write returns the previous word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_scratch_ram.sv
// rtl/cpu_scratch_ram.sv - CPU scratch RAM with clear sweep, write modes and optional output register
//
// Ports:
//   Clock    - clock, rising edge
//   Reset    - synchronous active-high reset; starts a clear sweep
//   ClockEn  - CPU port enable for reads, writes and Q updates
//   WE       - write enable, qualified by ClockEn
//   Address  - CPU word address
//   Data     - write data
//   Clear    - one-cycle request to zero the whole array
//   Q        - read data
//   Busy     - high while the clear sweep runs
module cpu_scratch_ram
    import cpu_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int WRITE_MODE = WM_NORMAL
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEn,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  Clear,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Busy
);

    localparam bit LP_NORMAL = (WRITE_MODE == WM_NORMAL);
    localparam bit LP_WTHRU  = (WRITE_MODE == WM_WRITETHROUGH);

    ram_state_t            r_state;
    ram_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    logic                  w_idle;
    logic                  w_host_wr;
    logic                  w_host_rd;
    logic                  w_core_we;
    logic                  w_core_re;
    logic [ADDR_WIDTH-1:0] w_core_addr;
    logic [DATA_WIDTH-1:0] w_core_wdata;
    logic [DATA_WIDTH-1:0] w_core_rdata;

    logic                  r_q_zero;
    logic                  r_q_fwd;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic [DATA_WIDTH-1:0] w_q1;

    // ---------------- FSM ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (Clear) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wraps back to 0 exactly as the sweep hands back to IDLE
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign Busy = (r_state == ST_CLEAR);

    // ---------------- array port muxing ----------------
    assign w_idle    = (r_state == ST_IDLE);
    assign w_host_wr = w_idle & ClockEn & WE & ~Clear;   // Clear drops a same-cycle write
    assign w_host_rd = w_idle & ClockEn;

    // Sweep writes run regardless of ClockEn; nothing is written while Reset is held
    assign w_core_we    = ~Reset & (~w_idle | w_host_wr);
    assign w_core_addr  = w_idle ? Address : r_cnt;
    assign w_core_wdata = w_idle ? Data : '0;

    // The array read is skipped on writes whose Q does not come from the array,
    // so its output register keeps the value Q should hold
    assign w_core_re = ~Reset & w_host_rd & ~(w_host_wr & (LP_NORMAL | LP_WTHRU));

    cpu_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_clk   (Clock),
        .i_we    (w_core_we),
        .i_re    (w_core_re),
        .i_addr  (w_core_addr),
        .i_wdata (w_core_wdata),
        .o_rdata (w_core_rdata)
    );

    // ---------------- first-stage Q selection ----------------
    // The array has no reset, so zero and write-through values are selected
    // around its output rather than loaded into it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q_zero   <= 1'b1;
            r_q_fwd    <= 1'b0;
            r_fwd_data <= '0;
        end else if (ClockEn) begin
            if (!w_idle) begin
                r_q_zero <= 1'b1;
                r_q_fwd  <= 1'b0;
            end else if (w_host_wr && LP_WTHRU) begin
                r_q_zero   <= 1'b0;
                r_q_fwd    <= 1'b1;
                r_fwd_data <= Data;
            end else if (!(w_host_wr && LP_NORMAL)) begin
                r_q_zero <= 1'b0;
                r_q_fwd  <= 1'b0;
            end
        end
    end

    assign w_q1 = r_q_zero ? '0 : (r_q_fwd ? r_fwd_data : w_core_rdata);

    // ---------------- optional output register ----------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q_out;
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    r_q_out <= '0;
                end else if (ClockEn) begin
                    r_q_out <= w_q1;
                end
            end
            assign Q = r_q_out;
        end else begin : g_no_out_reg
            assign Q = w_q1;
        end
    endgenerate

endmodule

// File: tb/tb_cpu_scratch_ram.sv
// tb/tb_cpu_scratch_ram.sv - self-checking bench for cpu_scratch_ram against a behavioural model
module tb_cpu_scratch_ram;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          ClockEn = 1'b0;
    logic          WE = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [DW-1:0] Data = '0;
    logic          Clear = 1'b0;

    logic [DW-1:0] q_n, q_w, q_r;
    logic          busy_n, busy_w, busy_r;

    always #5 Clock = ~Clock;

    // Three configurations driven by the same stimulus
    cpu_scratch_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0),
                      .WRITE_MODE(cpu_ram_pkg::WM_NORMAL)) dut_n (
        .Clock(Clock), .Reset(Reset), .ClockEn(ClockEn), .WE(WE), .Address(Address),
        .Data(Data), .Clear(Clear), .Q(q_n), .Busy(busy_n));

    cpu_scratch_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1),
                      .WRITE_MODE(cpu_ram_pkg::WM_WRITETHROUGH)) dut_w (
        .Clock(Clock), .Reset(Reset), .ClockEn(ClockEn), .WE(WE), .Address(Address),
        .Data(Data), .Clear(Clear), .Q(q_w), .Busy(busy_w));

    cpu_scratch_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0),
                      .WRITE_MODE(cpu_ram_pkg::WM_READBEFOREWRITE)) dut_r (
        .Clock(Clock), .Reset(Reset), .ClockEn(ClockEn), .WE(WE), .Address(Address),
        .Data(Data), .Clear(Clear), .Q(q_r), .Busy(busy_r));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: array contents, remaining sweep cycles, and per-instance
    // expected Q one and two cycles after the read
    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy_left = 0;
    logic [DW-1:0] m_q1 [3];
    logic [DW-1:0] m_q2 [3];
    int            m_mode [3] = '{0, 1, 2};
    int            m_oreg [3] = '{0, 1, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_q(input int i);
        return (m_oreg[i] != 0) ? m_q2[i] : m_q1[i];
    endfunction

    task automatic model_edge(input bit rst, input bit ce, input bit we,
                              input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clr);
        logic [DW-1:0] old;
        bit wr;
        for (int i = 0; i < 3; i++) begin
            if (rst) m_q2[i] = '0;
            else if (ce) m_q2[i] = m_q1[i];
        end
        if (rst) begin
            m_busy_left = DEPTH;
            for (int i = 0; i < 3; i++) m_q1[i] = '0;
        end else if (m_busy_left > 0) begin
            m_mem[DEPTH - m_busy_left] = '0;
            m_busy_left--;
            if (ce) for (int i = 0; i < 3; i++) m_q1[i] = '0;
        end else begin
            old = m_mem[a];
            wr  = ce && we && !clr;
            if (ce) begin
                for (int i = 0; i < 3; i++) begin
                    if (!wr) m_q1[i] = old;
                    else if (m_mode[i] == 1) m_q1[i] = d;
                    else if (m_mode[i] == 2) m_q1[i] = old;
                end
            end
            if (wr) m_mem[a] = d;
            if (clr) m_busy_left = DEPTH;
        end
    endtask

    task automatic step(input bit rst, input bit ce, input bit we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clr);
        Reset = rst; ClockEn = ce; WE = we; Address = a; Data = d; Clear = clr;
        @(posedge Clock);
        model_edge(rst, ce, we, a, d, clr);
        @(negedge Clock);
        check_val("busy_n", 32'(busy_n), 32'(m_busy_left > 0));
        check_val("busy_w", 32'(busy_w), 32'(m_busy_left > 0));
        check_val("busy_r", 32'(busy_r), 32'(m_busy_left > 0));
        check_val("q_normal", 32'(q_n), 32'(exp_q(0)));
        check_val("q_wthru_oreg", 32'(q_w), 32'(exp_q(1)));
        check_val("q_rbw", 32'(q_r), 32'(exp_q(2)));
    endtask

    // Steps with idle CPU inputs until Busy drops; returns the cycle count, bounded
    task automatic run_sweep(input bit ce, output int n);
        n = 0;
        do begin
            step(1'b0, ce, 1'b0, 4'($urandom_range(15, 0)), 8'($urandom), 1'b0);
            n++;
        end while (busy_n && n < 40);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < 3; i++) begin m_q1[i] = '0; m_q2[i] = '0; end

        // Reset 3 cycles, then a full sweep
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
            check_val("reset_busy", 32'(busy_n), 32'd1);
            check_val("reset_q", 32'(q_w), 32'd0);
        end
        run_sweep(1'b1, n);
        check_val("sweep_len_after_reset", 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), 8'd0, 1'b0);
            check_val("post_sweep_read_zero", 32'(q_n), 32'd0);
        end

        // Write 0xA5 to address 3 and read it back at both latencies
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        check_val("read_a5_lat1", 32'(q_n), 32'hA5);
        step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
        check_val("read_a5_lat2", 32'(q_w), 32'hA5);

        // Write-mode behaviour: address 5 holds 0x11, overwrite with 0x22
        step(1'b0, 1'b1, 1'b1, 4'd5, 8'h11, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'd5, 8'h22, 1'b0);
        check_val("wm_normal_keeps", 32'(q_n), 32'h11);
        check_val("wm_rbw_old", 32'(q_r), 32'h11);
        step(1'b0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
        check_val("wm_wthru_new", 32'(q_w), 32'h22);

        // Clear together with a write: write dropped
        step(1'b0, 1'b1, 1'b1, 4'd2, 8'h7E, 1'b1);
        check_val("clear_busy_rise", 32'(busy_n), 32'd1);
        run_sweep(1'b1, n);
        check_val("sweep_len_after_clear", 32'(n), 32'd16);
        step(1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
        check_val("clear_drops_write", 32'(q_n), 32'd0);

        // Reset mid-sweep restarts from address 0
        step(1'b0, 1'b1, 1'b1, 4'd0, 8'h5A, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        run_sweep(1'b1, n);
        check_val("sweep_len_after_midreset", 32'(n), 32'd16);

        // ClockEn low suppresses writes and holds Q
        step(1'b0, 1'b1, 1'b1, 4'd1, 8'h44, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'd1, 8'h33, 1'b0);
        check_val("ce0_holds_q", 32'(q_n), 32'h44);
        step(1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0);
        check_val("ce0_no_write", 32'(q_n), 32'h44);

        // Sweep proceeds with ClockEn low
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        run_sweep(1'b0, n);
        check_val("sweep_len_ce0", 32'(n), 32'd16);

        // Randomised traffic with occasional Clear and Reset
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99, 0) == 0),
                 ($urandom_range(3, 0) != 0),
                 ($urandom_range(1, 0) == 1),
                 4'($urandom_range(15, 0)),
                 8'($urandom),
                 ($urandom_range(59, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_scratch_ram.md
CPU_SCRATCH_RAM -- requirements
Module: cpu_scratch_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, address bits; depth = 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width in bits (legal 1..36).
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = one-cycle read, 1 = extra output register.
REQ-004 SHALL have parameter WRITE_MODE, default NORMAL; legal values are NORMAL, WRITETHROUGH and READBEFOREWRITE.
REQ-005 Clock  in  1  single clock; all logic on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 ClockEn  in  1  CPU port enable; gates reads, writes and Q updates.
REQ-008 WE  in  1  write enable, qualified by ClockEn.
REQ-009 Address  in  ADDR_WIDTH  CPU word address.
REQ-010 Data  in  DATA_WIDTH  write data.
REQ-011 Clear  in  1  one-cycle request to zero the whole array.
REQ-012 Q  out  DATA_WIDTH  read data.
REQ-013 Busy  out  1  high while the clear sweep runs.

Function
REQ-014 SHALL use FSM states IDLE and CLEAR, plus a clear counter of ADDR_WIDTH bits.
REQ-015 In IDLE, ClockEn=1 and WE=1 SHALL write Data to Address at the edge.
REQ-016 In IDLE, ClockEn=1 SHALL read Address; with OUT_REG=0, Q is valid 1 cycle later; with OUT_REG=1, Q is valid 2 cycles later.
REQ-017 On a write: NORMAL SHALL leave Q unchanged; WRITETHROUGH SHALL present the new Data on Q; READBEFOREWRITE SHALL present the old word on Q.
REQ-018 ClockEn=0 SHALL hold Q and the output register and SHALL suppress writes.
REQ-019 Clear=1 in IDLE SHALL enter CLEAR at the next edge with counter=0; Busy SHALL be high from that edge.
REQ-020 Clear and WE asserted in the same IDLE cycle SHALL drop the write; Clear wins.
REQ-021 In CLEAR, each cycle SHALL write 0 to address=counter and increment the counter, independent of ClockEn.
REQ-022 The cycle that writes address 2^ADDR_WIDTH-1 SHALL be the last; the next edge SHALL enter IDLE with Busy=0; Busy is high for exactly 2^ADDR_WIDTH cycles.
REQ-023 While Busy, WE SHALL be ignored, Q SHALL read 0 (after the read latency), and Clear SHALL be ignored (no restart).
REQ-024 Counter wrap from max to 0 SHALL occur only on the CLEAR-to-IDLE transition; no further clear writes follow.

Reset
REQ-025 Reset=1 SHALL force Q=0, zero the output register, set the state to CLEAR, set counter=0 and set Busy=1 at the same edge.
REQ-026 While Reset is held, the counter SHALL stay 0 and no address beyond 0 SHALL be written.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-028 After Reset falls, Busy SHALL remain high for exactly 2^ADDR_WIDTH cycles.
REQ-029 Array contents at power-up are undefined until the first sweep completes.

Structure
REQ-030 Package cpu_ram_pkg SHALL hold the FSM state type and the WRITE_MODE constants.
REQ-031 Storage SHALL be one sub-module, cpu_ram_core: a plain single-port synchronous array with no reset, inferable to EBR.
REQ-032 The FSM, the counter, the address/data/WE muxing, the write-mode logic and OUT_REG SHALL sit in cpu_scratch_ram.

Verification
REQ-033 ADDR_WIDTH=4, Reset 3 cycles -> Busy high during Reset plus 16 cycles; then reading every address -> 0x00.
REQ-034 Write 0xA5 to address 3, then read address 3 -> Q=0xA5 after 1 cycle (OUT_REG=0) or after 2 cycles (OUT_REG=1).
REQ-035 WRITE_MODE sweep: address 5 holds 0x11; write 0x22 -> Q=0x11 for NORMAL (previous read), 0x22 for WRITETHROUGH, 0x11 for READBEFOREWRITE.
REQ-036 Clear together with WE (Data 0x7E, address 2) -> write dropped; after Busy falls, address 2 reads 0x00.
REQ-037 Reset at sweep cycle 8 -> sweep restarts at address 0; Busy stays high for a full 16 cycles after Reset falls.
REQ-038 ClockEn=0 with WE=1 (Data 0x33, address 1) -> no write and Q held; with ClockEn=0 during a sweep -> Busy still falls after 16 cycles.
